ariane_profile_reader: RTL

ARIANE_PROFILE_READER -- requirements
Module: ariane_profile_reader

---
 rtl/ariane_profile_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/ariane_profile_reader.sv
// Snapshots all profiling counters in one edge, then drains them as data_width_p words, LS word first.
// Latency: first word valid the cycle after accept; one word per cycle under ready_i, done_o pulse after the last.
// Backpressure: ready_i low holds data_o/idx_o/last_o; snap_v_i is only accepted in IDLE, never queued.
module ariane_profile_reader #(
    parameter int width_p      = 64,
    parameter int els_p        = 35,
    parameter int data_width_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p*width_p-1:0]   counters_i,
    input  logic                       snap_v_i,
    output logic                       snap_ready_o,
    input  logic                       abort_i,
    output logic                       v_o,
    input  logic                       ready_i,
    output logic [data_width_p-1:0]    data_o,
    output logic [$clog2(els_p)-1:0]   idx_o,
    output logic                       last_o,
    output logic                       done_o
);

    localparam int words_per_ctr = width_p / data_width_p;
    localparam int idx_w         = $clog2(els_p);
    localparam int word_w        = (words_per_ctr > 1) ? $clog2(words_per_ctr) : 1;

    localparam logic [idx_w-1:0]  last_idx  = idx_w'(els_p - 1);
    localparam logic [word_w-1:0] last_word = word_w'(words_per_ctr - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Same bit layout as counters_i, viewed as [counter][word] for direct word selection.
    logic [els_p-1:0][words_per_ctr-1:0][data_width_p-1:0] shadow_q, shadow_d;
    logic [idx_w-1:0]  idx_q, idx_d;
    logic [word_w-1:0] word_q, word_d;

    logic accept;
    logic xfer;
    logic at_last;

    assign accept  = (state_q == IDLE) && snap_v_i;
    assign xfer    = (state_q == SEND) && ready_i && !abort_i;
    assign at_last = (idx_q == last_idx) && (word_q == last_word);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (snap_v_i) state_d = SEND;
            end
            SEND: begin
                if (abort_i)               state_d = IDLE;
                else if (ready_i && at_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Indices stop on the final word so idx_o never steps past els_p-1.
    always_comb begin
        shadow_d = shadow_q;
        idx_d    = idx_q;
        word_d   = word_q;
        if (accept) begin
            shadow_d = counters_i;
            idx_d    = '0;
            word_d   = '0;
        end else if (xfer && !at_last) begin
            if (word_q == last_word) begin
                word_d = '0;
                idx_d  = idx_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    always_comb begin
        snap_ready_o = (state_q == IDLE) && !reset_i;
        v_o          = (state_q == SEND);
        last_o       = (state_q == SEND) && at_last;
        done_o       = (state_q == DONE);
        data_o       = '0;
        if (state_q == SEND) data_o = shadow_q[idx_q][word_q];
        idx_o        = idx_q;
    end

endmodule
